axi_rom_rd_slave: RTL
=====================

// Module: axi_rom_rd_slave
// PURPOSE
//  AXI4 read-only responder serving instruction/boot memory to the icache AXI read port via the crossbar.
//  Accepts one AR burst at a time, walks burst addresses into a synchronous 1-cycle-latency memory.
//  Returns R beats with ID, RESP and RLAST; absorbs RREADY backpressure in a 3-entry output FIFO.
// PARAMETERS
//  AXI_ADDR_WIDTH   32            AR address width
//  AXI_DATA_WIDTH   64            R data width; DATA_BYTES = AXI_DATA_WIDTH/8
//  AXI_ID_WIDTH     4             ARID/RID width
//  MEM_DEPTH_WORDS  4096          memory depth in AXI_DATA_WIDTH words; MW = $clog2(MEM_DEPTH_WORDS)
//  BASE_ADDR        32'h0000_0000 byte base of decoded window; must be DATA_BYTES*MEM_DEPTH_WORDS aligned
// PORTS
//  clk_i           in   1                single clock
//  rst_i           in   1                reset: synchronous, active-high
//  s_ar_id_i       in   AXI_ID_WIDTH     ARID
//  s_ar_addr_i     in   AXI_ADDR_WIDTH   ARADDR (byte)
//  s_ar_len_i      in   8                ARLEN (beats-1)
//  s_ar_size_i     in   3                ARSIZE
//  s_ar_burst_i    in   2                ARBURST (FIXED=0, INCR=1, WRAP=2)
//  s_ar_valid_i    in   1                ARVALID
//  s_ar_ready_o    out  1                ARREADY
//  s_r_id_o        out  AXI_ID_WIDTH     RID
//  s_r_data_o      out  AXI_DATA_WIDTH   RDATA
//  s_r_resp_o      out  2                RRESP (OKAY=0, SLVERR=2, DECERR=3)
//  s_r_last_o      out  1                RLAST
//  s_r_valid_o     out  1                RVALID
//  s_r_ready_i     in   1                RREADY
//  mem_req_o       out  1                memory read strobe
//  mem_addr_o      out  MW               memory word index
//  mem_rdata_i     in   AXI_DATA_WIDTH   read data, valid exactly 1 cycle after mem_req_o
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=IDLE; s_ar_ready_o=1; s_r_valid_o=0, s_r_last_o=0; s_r_id/data/resp=0;
//   mem_req_o=0, mem_addr_o=0; FIFO empty; counters 0; in-flight mem data discarded. Applies mid-burst.
//  FSM IDLE: s_ar_ready_o=1; on AR handshake latch id/addr/len/size/burst, classify resp -> BURST.
//   BURST: s_ar_ready_o=0; issue one beat/cycle while (fifo_count + inflight) < 3; beat counter 0..len.
//   After last beat issued -> DRAIN. DRAIN: s_ar_ready_o=0; when FIFO empty and inflight=0 -> IDLE.
//  Classification (fixed per burst): addr outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH_WORDS*DATA_BYTES) -> DECERR;
//   else ARSIZE != log2(DATA_BYTES) -> SLVERR; else WRAP with len not in {1,3,7,15} -> SLVERR; else OKAY.
//   Error bursts: no mem_req_o, still return len+1 beats, data=0, resp constant, RLAST on final beat.
//  Addressing: word = (addr-BASE_ADDR)>>log2(DATA_BYTES), truncated to MW bits.
//   FIXED: same word each beat. INCR: word+1 per beat, modulo 2^MW (no 4KB check).
//   WRAP: word wraps within (len+1)-word aligned block; low log2(len+1) bits increment, upper bits held.
//  FIFO entry {data,resp,last,id}; head drives R outputs; pop on RVALID&&RREADY; R outputs stable while RVALID&&!RREADY.
//  Latency: AR handshake cycle T -> mem_req_o at T+1 -> data push T+2 -> RVALID at T+3.
//   Sustained 1 beat/cycle when RREADY held 1; next AR accepted the cycle after return to IDLE.
//  Simultaneous push+pop with FIFO full not reachable (issue throttle); push+pop same cycle keeps count.
//  len=0: single beat, RLAST=1. len=255: 256 beats, beat counter 8 bits plus done flag.
// CONFIGURATION
//  AXI_RD_SLV_WRAP_EN defined: WRAP bursts decoded as above.
//  Not defined: any WRAP burst classified SLVERR (after DECERR check); FIXED/INCR unchanged.
// STRUCTURE
//  interconnect_pkg: axi_burst_e {FIXED,INCR,WRAP}, axi_resp_e {OKAY,EXOKAY,SLVERR,DECERR}, rd_slv_state_e {IDLE,BURST,DRAIN}.
//  Sub-module axi_burst_addr_gen: latched start word/len/burst -> next word index (combinational + beat register).
//  FIFO (3 entries, 2-bit pointers, count 0..3) local to this module.
// TESTING
//  INCR id=5 addr=0x100 len=3 size=3, RREADY=1 -> words 0x20..0x23, RID=5, OKAY, RLAST beat 4, RVALID first at T+3.
//  WRAP addr=0x118 len=3 (macro on) -> words 0x23,0x20,0x21,0x22; macro off -> 4 beats SLVERR, data 0, no mem_req_o.
//  addr=BASE+0x8000 (out of window) len=1 -> 2 beats DECERR, no mem_req_o, then ARREADY=1 again.
//  INCR len=7 with RREADY toggled 1,0,0,1,... -> all 8 beats in order, no loss/duplication, R outputs stable while stalled.
//  size=2 on 64-bit bus len=0 -> single SLVERR beat RLAST=1; FIXED addr=0x40 len=2 -> word 0x8 three times.
//  rst_i asserted mid INCR len=15 at beat 5 -> next cycle RVALID=0, ARREADY=1, new burst returns correct data.

Source files
------------

// File: rtl/axi_rom_rd_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rom_rd_slave_pkg
// Description : Shared AXI burst/response encodings and read-slave FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rom_rd_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } rd_slv_state_e;

  localparam int unsigned c_fifo_depth = 3;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Pointer wraps at the FIFO depth, which is not a power of two.
  function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(c_fifo_depth - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rom_rd_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rom_rd_slave_if
// Description : AXI4 read-address and read-data channel bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rom_rd_slave_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_valid;
  logic                      ar_ready;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    input  ar_ready, r_id, r_data, r_resp, r_last, r_valid
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    output ar_ready, r_id, r_data, r_resp, r_last, r_valid
  );
endinterface
`default_nettype wire

// File: rtl/axi_rom_rd_slave_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Beat counter plus FIXED/INCR/WRAP word-index generation.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
  import axi_rom_rd_slave_pkg::*;
#(
  parameter int MW = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [MW-1:0] start_word_i,
  input  logic [7:0]    len_i,
  input  axi_burst_e    burst_i,
  output logic [MW-1:0] word_o,
  output logic          last_o
);
  logic [7:0]    beat_q;
  logic [MW-1:0] w_offset;
  logic [MW-1:0] w_wrap_mask;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      beat_q <= '0;
    end else if (advance_i) begin
      beat_q <= beat_q + 8'd1;
    end
  end

  // WRAP lengths are 2^n-1, so len itself is the mask of the incrementing bits.
  always_comb begin
    w_offset    = MW'(beat_q);
    w_wrap_mask = MW'(len_i);
    word_o      = start_word_i + w_offset;
    unique case (burst_i)
      BURST_FIXED: word_o = start_word_i;
      BURST_WRAP:  word_o = (start_word_i & ~w_wrap_mask) |
                            ((start_word_i + w_offset) & w_wrap_mask);
      default:     word_o = start_word_i + w_offset;
    endcase
  end

  assign last_o = (beat_q == len_i);

endmodule
`default_nettype wire

// File: rtl/axi_rom_rd_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_rom_rd_slave
// Description : AXI4 read-only responder over a 1-cycle-latency memory with a
//               3-entry R FIFO. Define AXI_RD_SLV_WRAP_EN to decode WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rom_rd_slave
  import axi_rom_rd_slave_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int MEM_DEPTH_WORDS = 4096,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int MW = $clog2(MEM_DEPTH_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  axi_rom_rd_slave_if.slave         s_axi,
  output logic                      mem_req_o,
  output logic [MW-1:0]             mem_addr_o,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int          c_data_bytes = AXI_DATA_WIDTH / 8;
  localparam int          c_size_log2  = $clog2(c_data_bytes);
  localparam logic [63:0] c_window     = 64'(MEM_DEPTH_WORDS) * 64'(c_data_bytes);

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    axi_resp_e                 resp;
    logic                      last;
    logic [AXI_ID_WIDTH-1:0]   id;
  } fifo_entry_t;

  rd_slv_state_e           state_q, state_d;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [7:0]              len_q;
  axi_burst_e              burst_q;
  axi_resp_e               resp_q;
  logic [MW-1:0]           start_q;
  logic                    inflight_q, pend_last_q;
  fifo_entry_t             fifo_q [c_fifo_depth];
  logic [1:0]              wr_ptr_q, rd_ptr_q, count_q;

  logic                    w_ar_hs, w_issue, w_beat_last, w_push, w_pop;
  logic [AXI_ADDR_WIDTH:0] w_ar_off;
  logic [MW-1:0]           w_ar_word, w_beat_word;
  axi_resp_e               w_ar_resp;
  fifo_entry_t             w_push_entry, w_head;

  always_comb begin
    w_ar_off  = {1'b0, s_axi.ar_addr} - {1'b0, BASE_ADDR};
    w_ar_word = MW'(w_ar_off[AXI_ADDR_WIDTH-1:0] >> c_size_log2);
    w_ar_resp = RESP_OKAY;
    if (w_ar_off[AXI_ADDR_WIDTH] || (64'(w_ar_off[AXI_ADDR_WIDTH-1:0]) >= c_window)) begin
      w_ar_resp = RESP_DECERR;
    end else if (s_axi.ar_size != 3'(c_size_log2)) begin
      w_ar_resp = RESP_SLVERR;
    end else if (s_axi.ar_burst == BURST_WRAP) begin
`ifdef AXI_RD_SLV_WRAP_EN
      if (!wrap_len_ok(s_axi.ar_len)) w_ar_resp = RESP_SLVERR;
`else
      w_ar_resp = RESP_SLVERR;
`endif
    end
  end

  // Throttle counts in-flight reads so a push can never find the FIFO full.
  always_comb begin
    state_d        = state_q;
    s_axi.ar_ready = (state_q == ST_IDLE);
    w_ar_hs        = s_axi.ar_ready && s_axi.ar_valid;
    w_issue        = (state_q == ST_BURST) &&
                     (({1'b0, count_q} + {2'b0, inflight_q}) < 3'(c_fifo_depth));
    unique case (state_q)
      ST_IDLE:  if (w_ar_hs) state_d = ST_BURST;
      ST_BURST: if (w_issue && w_beat_last) state_d = ST_DRAIN;
      ST_DRAIN: if ((count_q == 2'd0) && !inflight_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      len_q       <= '0;
      burst_q     <= BURST_FIXED;
      resp_q      <= RESP_OKAY;
      start_q     <= '0;
      inflight_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= w_issue;
      pend_last_q <= w_issue && w_beat_last;
      if (w_ar_hs) begin
        id_q    <= s_axi.ar_id;
        len_q   <= s_axi.ar_len;
        burst_q <= axi_burst_e'(s_axi.ar_burst);
        resp_q  <= w_ar_resp;
        start_q <= w_ar_word;
      end
    end
  end

  axi_burst_addr_gen #(.MW(MW)) u_addr_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (w_ar_hs),
    .advance_i    (w_issue),
    .start_word_i (start_q),
    .len_i        (len_q),
    .burst_i      (burst_q),
    .word_o       (w_beat_word),
    .last_o       (w_beat_last)
  );

  // Error bursts walk the same pipeline but never touch the memory.
  assign mem_req_o  = w_issue && (resp_q == RESP_OKAY);
  assign mem_addr_o = mem_req_o ? w_beat_word : '0;

  assign w_push = inflight_q;
  assign w_pop  = (count_q != 2'd0) && s_axi.r_ready;
  assign w_head = fifo_q[rd_ptr_q];

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = (resp_q == RESP_OKAY) ? mem_rdata_i : '0;
    w_push_entry.resp = resp_q;
    w_push_entry.last = pend_last_q;
    w_push_entry.id   = id_q;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) fifo_q[wr_ptr_q] <= w_push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= fifo_ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= fifo_ptr_inc(rd_ptr_q);
      if (w_push && !w_pop)      count_q <= count_q + 2'd1;
      else if (!w_push && w_pop) count_q <= count_q - 2'd1;
    end
  end

  assign s_axi.r_valid = (count_q != 2'd0);
  assign s_axi.r_id    = s_axi.r_valid ? w_head.id   : '0;
  assign s_axi.r_data  = s_axi.r_valid ? w_head.data : '0;
  assign s_axi.r_resp  = s_axi.r_valid ? w_head.resp : RESP_OKAY;
  assign s_axi.r_last  = s_axi.r_valid && w_head.last;

endmodule
`default_nettype wire
